// File: rtl/icache_sa_if.sv
// Fetch and burst-memory signals of icache_sa in one bundle.
// The slave modport is the cache's view; master is the environment (fetch stage plus memory).
interface icache_sa_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ok;
  logic        stall;
  logic        inv;
  logic        inv_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  req, addr, inv, mem_addr_ok, mem_data_ok, mem_rdata,
    output rdata, ok, stall, inv_ack, mem_req, mem_addr, hit_cnt, miss_cnt
  );

  modport master (
    output req, addr, inv, mem_addr_ok, mem_data_ok, mem_rdata,
    input  rdata, ok, stall, inv_ack, mem_req, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_sa.sv
// Parametrised N-way set-associative read-only I-cache with exact LRU ages and burst refill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_sa #(
  parameter int WAYS       = 4,
  parameter int SET_BITS   = 8,
  parameter int LINE_WORDS = 16
) (
  input logic        clk,
  input logic        rst_n,
  icache_sa_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP, S_INV
  } state_e;

  state_e state_q, state_d;

  logic [29:0]       addr_q;
  logic [OFF_W-1:0]  cnt_q;
  logic [WAY_W-1:0]  victim_q;
  logic [31:0]       resp_q;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];

  logic [TAG_W-1:0]  tagMem  [WAYS][SETS];
  logic [31:0]       dataMem [WAYS][SETS*LINE_WORDS];
  logic [TAG_W-1:0]  rdTag_q  [WAYS];
  logic [31:0]       rdData_q [WAYS];

  logic [OFF_W-1:0]    curWord;
  logic [SET_BITS-1:0] curSet;
  logic [TAG_W-1:0]    curTag;
  logic [OFF_W-1:0]    rdWord;
  logic [SET_BITS-1:0] rdSet;

  assign curWord = addr_q[OFF_W-1:0];
  assign curSet  = addr_q[OFF_W +: SET_BITS];
  assign curTag  = addr_q[29 -: TAG_W];
  assign rdWord  = bus.addr[OFF_W+1:2];
  assign rdSet   = bus.addr[OFF_W+2 +: SET_BITS];

  logic             hit;
  logic [WAY_W-1:0] hitWay;
  logic [31:0]      hitWord;

  always_comb begin
    hit     = 1'b0;
    hitWay  = '0;
    hitWord = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][curSet] && rdTag_q[w] == curTag) begin
        hit     = 1'b1;
        hitWay  = WAY_W'(w);
        hitWord = rdData_q[w];
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest way, ties resolved toward the lowest index.
  logic [WAY_W-1:0] victim;
  logic             foundInvalid;

  always_comb begin
    victim       = '0;
    foundInvalid = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][curSet]) begin
        victim       = WAY_W'(w);
        foundInvalid = 1'b1;
      end
    end
    if (!foundInvalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[curSet][w] > age_q[curSet][victim]) begin
          victim = WAY_W'(w);
        end
      end
    end
  end

  logic             lruEn;
  logic [WAY_W-1:0] lruWay;
  logic [WAY_W-1:0] ageNew [WAYS];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      ageNew[w] = age_q[curSet][w];
      if (age_q[curSet][w] < age_q[curSet][lruWay]) begin
        ageNew[w] = age_q[curSet][w] + WAY_W'(1);
      end
    end
    ageNew[lruWay] = '0;
  end

  logic        rdEn;
  logic        beat;
  logic        refillLast;
  logic        cacheOk;
  logic [31:0] cacheRdata;
  logic        cacheStall;
  logic        invAck;
  logic        memReq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rdEn       = 1'b0;
    beat       = 1'b0;
    refillLast = 1'b0;
    lruEn      = 1'b0;
    lruWay     = hitWay;
    cacheOk    = 1'b0;
    cacheRdata = resp_q;
    cacheStall = 1'b0;
    invAck     = 1'b0;
    memReq     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.inv) begin
          state_d = S_INV;
        end else if (bus.req) begin
          rdEn    = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cacheOk    = 1'b1;
          cacheRdata = hitWord;
          lruEn      = 1'b1;
          if (bus.req && !bus.inv) begin
            rdEn    = 1'b1;
            state_d = S_LOOKUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cacheStall = 1'b1;
          state_d    = S_MISS;
        end
      end
      S_MISS: begin
        cacheStall = 1'b1;
        memReq     = 1'b1;
        if (bus.mem_addr_ok) begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        cacheStall = 1'b1;
        if (bus.mem_data_ok) begin
          beat = 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            refillLast = 1'b1;
            lruEn      = 1'b1;
            lruWay     = victim_q;
            state_d    = S_RESP;
          end
        end
      end
      S_RESP: begin
        cacheStall = 1'b1;
        cacheOk    = 1'b1;
        state_d    = S_IDLE;
      end
      S_INV: begin
        cacheStall = 1'b1;
        invAck     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid bits and ages are flops so that invalidate and reset can touch every set at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
      resp_q   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      if (rdEn) begin
        addr_q <= bus.addr[31:2];
      end
      if (state_q == S_LOOKUP && !hit) begin
        victim_q <= victim;
      end
      if (state_q == S_MISS) begin
        cnt_q <= '0;
      end
      if (beat) begin
        cnt_q <= cnt_q + OFF_W'(1);
        if (cnt_q == curWord) begin
          resp_q <= bus.mem_rdata;
        end
      end
      if (refillLast) begin
        valid_q[victim_q][curSet] <= 1'b1;
      end
      if (lruEn) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[curSet][w] <= ageNew[w];
        end
      end
      if (state_q == S_INV) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      dataMem[victim_q][{curSet, cnt_q}] <= bus.mem_rdata;
    end
    if (refillLast) begin
      tagMem[victim_q][curSet] <= curTag;
    end
    if (rdEn) begin
      for (int w = 0; w < WAYS; w++) begin
        rdTag_q[w]  <= tagMem[w][rdSet];
        rdData_q[w] <= dataMem[w][{rdSet, rdWord}];
      end
    end
  end

  assign bus.ok       = cacheOk;
  assign bus.rdata    = cacheRdata;
  assign bus.stall    = cacheStall;
  assign bus.inv_ack  = invAck;
  assign bus.mem_req  = memReq;
  assign bus.mem_addr = {addr_q[29:OFF_W], {(OFF_W + 2){1'b0}}};

`ifdef ICACHE_PERF_EN
  logic [31:0] hitCnt_q;
  logic [31:0] missCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) begin
        hitCnt_q <= hitCnt_q + 32'd1;
      end else begin
        missCnt_q <= missCnt_q + 32'd1;
      end
    end
  end

  assign bus.hit_cnt  = hitCnt_q;
  assign bus.miss_cnt = missCnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: scripted vectors, refill corner cases and randomized reads
// against a recency-list model of an LRU set-associative cache.
module tb_icache_sa;

  localparam int WAYS     = 4;
  localparam int SET_BITS = 8;
  localparam int LW       = 16;

  logic clk;
  logic rst_n;

  icache_sa_if bus ();

  icache_sa #(
    .WAYS(WAYS),
    .SET_BITS(SET_BITS),
    .LINE_WORDS(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nHit   = 0;
  int nMiss  = 0;

  // Resident lines, most recently used first, across all sets.
  logic [25:0] lines [$];

  typedef enum logic {OP_READ, OP_INV} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic        expHit;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'hA000_0000 + ((a >> 2) - 32'h0000_0410);
  endfunction

  function automatic logic modelLookup(input logic [31:0] a);
    logic [25:0] ln;
    int          inSet;
    ln    = a[31:6];
    inSet = 0;
    for (int i = 0; i < lines.size(); i++) begin
      if (lines[i] == ln) begin
        lines.delete(i);
        lines.push_front(ln);
        return 1'b1;
      end
    end
    for (int i = 0; i < lines.size(); i++) begin
      if (lines[i][7:0] == ln[7:0]) inSet++;
    end
    if (inSet == WAYS) begin
      for (int i = lines.size() - 1; i >= 0; i--) begin
        if (lines[i][7:0] == ln[7:0]) begin
          lines.delete(i);
          break;
        end
      end
    end
    lines.push_front(ln);
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounters();
`ifdef ICACHE_PERF_EN
    checkOutput("hit_cnt", bus.hit_cnt, nHit);
    checkOutput("miss_cnt", bus.miss_cnt, nMiss);
`else
    checkOutput("hit_cnt", bus.hit_cnt, 32'd0);
    checkOutput("miss_cnt", bus.miss_cnt, 32'd0);
`endif
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ok", bus.ok, 0);
    checkOutput("rst_inv_ack", bus.inv_ack, 0);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_stall", bus.stall, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_hit_cnt", bus.hit_cnt, 0);
    checkOutput("rst_miss_cnt", bus.miss_cnt, 0);
  endtask

  task automatic invalidateAll();
    bus.inv = 1'b1;
    stepCycle();
    checkOutput("inv_ack", bus.inv_ack, 1);
    checkOutput("inv_stall", bus.stall, 1);
    bus.inv = 1'b0;
    stepCycle();
    checkOutput("inv_ack_drop", bus.inv_ack, 0);
    lines.delete();
  endtask

  // One fetch from IDLE; on a miss it plays the memory side, with optional inv or reset mid-burst.
  task automatic readLine(input logic [31:0] a, input logic expHit, input int invBeat, input int rstBeat);
    logic [31:0] line;
    line     = {a[31:6], 6'b0};
    bus.req  = 1'b1;
    bus.addr = a;
    stepCycle();
    checkOutput("lookup_ok", bus.ok, expHit);
    checkOutput("lookup_stall", bus.stall, !expHit);
    if (expHit) begin
      checkOutput("hit_rdata", bus.rdata, memval(a));
      checkOutput("hit_mem_req", bus.mem_req, 0);
      nHit++;
      bus.req = 1'b0;
      stepCycle();
      checkOutput("hit_ok_drop", bus.ok, 0);
      checkCounters();
      return;
    end
    nMiss++;
    bus.addr = $urandom;
    stepCycle();
    checkOutput("miss_mem_req", bus.mem_req, 1);
    checkOutput("miss_mem_addr", bus.mem_addr, line);
    repeat ($urandom_range(0, 2)) begin
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = $urandom;
      stepCycle();
      checkOutput("miss_hold_req", bus.mem_req, 1);
    end
    bus.mem_data_ok = 1'b0;
    bus.mem_addr_ok = 1'b1;
    stepCycle();
    bus.mem_addr_ok = 1'b0;
    checkOutput("refill_mem_req_low", bus.mem_req, 0);
    for (int i = 0; i < LW; i++) begin
      repeat ($urandom_range(0, 1)) begin
        bus.mem_rdata = $urandom;
        stepCycle();
      end
      if (i == invBeat) bus.inv = 1'b1;
      if (i == rstBeat) begin
        bus.req         = 1'b0;
        bus.inv         = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = $urandom;
        rst_n           = 1'b0;
        #1;
        checkResetOutputs();
        repeat (2) stepCycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          bus.mem_rdata = $urandom;
          stepCycle();
          checkOutput("stray_ok", bus.ok, 0);
          checkOutput("stray_stall", bus.stall, 0);
          checkOutput("stray_mem_req", bus.mem_req, 0);
        end
        bus.mem_data_ok = 1'b0;
        lines.delete();
        nHit  = 0;
        nMiss = 0;
        checkCounters();
        return;
      end
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = memval(line + 32'(4 * i));
      stepCycle();
      bus.mem_data_ok = 1'b0;
      if (i < LW - 1) checkOutput("refill_ok_early", bus.ok, 0);
    end
    checkOutput("resp_ok", bus.ok, 1);
    checkOutput("resp_rdata", bus.rdata, memval(a));
    bus.req = 1'b0;
    stepCycle();
    checkOutput("resp_ok_drop", bus.ok, 0);
    if (invBeat >= 0) begin
      checkOutput("late_inv_ack_wait", bus.inv_ack, 0);
      stepCycle();
      checkOutput("late_inv_ack", bus.inv_ack, 1);
      bus.inv = 1'b0;
      stepCycle();
      lines.delete();
    end
    checkCounters();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.op == OP_INV) begin
      invalidateAll();
    end else begin
      void'(modelLookup(v.addr));
      readLine(v.addr, v.expHit, -1, -1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b2bAddr [4];
    logic [31:0] a;

    clk             = 1'b0;
    rst_n           = 1'b0;
    bus.req         = 1'b0;
    bus.addr        = '0;
    bus.inv         = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;

    vecs[0] = '{OP_INV,  32'h0000_0000, 1'b0};
    vecs[1] = '{OP_READ, 32'h0000_1048, 1'b0};
    vecs[2] = '{OP_READ, 32'h0004_1040, 1'b0};
    vecs[3] = '{OP_READ, 32'h0008_1040, 1'b0};
    vecs[4] = '{OP_READ, 32'h000C_1040, 1'b0};
    vecs[5] = '{OP_READ, 32'h0000_1040, 1'b1};
    vecs[6] = '{OP_READ, 32'h0010_1040, 1'b0};
    vecs[7] = '{OP_READ, 32'h0000_1040, 1'b1};
    vecs[8] = '{OP_READ, 32'h0004_1040, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst_n = 1'b1;
    stepCycle();
    checkResetOutputs();

    void'(modelLookup(32'h0000_1048));
    readLine(32'h0000_1048, 1'b0, -1, -1);
    checkOutput("cold_word2", memval(32'h0000_1048), 32'hA000_0002);

    b2bAddr = '{32'h1040, 32'h1044, 32'h1048, 32'h107C};
    bus.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.addr = b2bAddr[k];
      void'(modelLookup(b2bAddr[k]));
      stepCycle();
      checkOutput("b2b_ok", bus.ok, 1);
      checkOutput("b2b_rdata", bus.rdata, memval(b2bAddr[k]));
      checkOutput("b2b_mem_req", bus.mem_req, 0);
      nHit++;
    end
    bus.req = 1'b0;
    stepCycle();
    checkOutput("b2b_ok_drop", bus.ok, 0);
    checkCounters();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    void'(modelLookup(32'h0000_2004));
    readLine(32'h0000_2004, 1'b0, 5, -1);
    void'(modelLookup(32'h0000_2004));
    readLine(32'h0000_2004, 1'b0, -1, -1);

    void'(modelLookup(32'h0000_3048));
    readLine(32'h0000_3048, 1'b0, -1, 7);
    void'(modelLookup(32'h0000_3048));
    readLine(32'h0000_3048, 1'b0, -1, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        invalidateAll();
      end else begin
        a = (32'($urandom_range(0, 5)) << 14) | (32'($urandom_range(8'h41, 8'h42)) << 6)
          | (32'($urandom_range(0, LW - 1)) << 2);
        readLine(a, modelLookup(a), -1, -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
